trigger_event_gen: RTL

Event detector that turns activity on a monitored 32-bit counter into single-cycle trigger pulses for a FrontPanel TriggerOut endpoint, plus a sticky status word and an event tally for WireOut endpoints. It complements TriggerIn-driven counter control by carrying events back to the host. It sits in the `sys_clk` domain between the user counters and the endpoint instances.

---
 rtl/trigger_event_gen.sv | 108 ++++++++++
 1 files changed

// File: rtl/trigger_event_gen.sv
// Counter event detector feeding a TriggerOut endpoint: threshold crossings, wraps and
// changes become one-cycle pulses, with a sticky status word and a saturating event tally.
module trigger_event_gen #(
  parameter bit ONESHOT = 1'b0
) (
  input  logic        i_sys_clk,
  input  logic        i_reset,
  input  logic [31:0] i_count_in,
  input  logic [31:0] i_threshold_hi,
  input  logic [31:0] i_threshold_lo,
  input  logic        i_arm,
  input  logic        i_disarm,
  input  logic        i_clear,
  output logic [15:0] o_trig_out,
  output logic [15:0] o_status,
  output logic [15:0] o_event_count,
  output logic        o_armed
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRIME,
    S_ARMED
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_cur;
  logic [31:0] r_prev;
  logic [15:0] r_trig;
  logic [15:0] r_status;
  logic [15:0] r_count;
  logic [15:0] w_events;
  logic        w_detect;
  logic        w_any_event;

  always_ff @(posedge i_sys_clk) begin
    if (i_reset) begin
      r_cur  <= '0;
      r_prev <= '0;
    end else begin
      r_cur  <= i_count_in;
      r_prev <= r_cur;
    end
  end

  // A disarm in the same cycle suppresses the comparison evaluated at that edge.
  assign w_detect = (r_state == S_ARMED) && !i_disarm;

  always_comb begin
    w_events = '0;
    if (w_detect) begin
      w_events[0] = (r_prev <= i_threshold_hi) && (r_cur > i_threshold_hi);
      w_events[1] = (r_prev >= i_threshold_lo) && (r_cur < i_threshold_lo);
      w_events[2] = (r_prev == 32'hFFFF_FFFF) && (r_cur == 32'h0000_0000);
      w_events[3] = (r_prev == 32'h0000_0000) && (r_cur == 32'hFFFF_FFFF);
      w_events[4] = (r_cur != r_prev);
    end
  end

  assign w_any_event = |w_events;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_arm && !i_disarm) w_state_next = S_PRIME;
      end
      S_PRIME: begin
        w_state_next = i_disarm ? S_IDLE : S_ARMED;
      end
      S_ARMED: begin
        if (i_disarm) w_state_next = S_IDLE;
        else if (ONESHOT && (|w_events[1:0])) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  // An event coinciding with clear wins: status restarts from the new bits, tally from 1.
  always_ff @(posedge i_sys_clk) begin
    if (i_reset) begin
      r_trig   <= '0;
      r_status <= '0;
      r_count  <= '0;
    end else begin
      r_trig   <= w_events;
      r_status <= (i_clear ? 16'h0000 : r_status) | w_events;
      if (w_any_event) begin
        if (i_clear)                   r_count <= 16'd1;
        else if (r_count != 16'hFFFF)  r_count <= r_count + 16'd1;
      end else if (i_clear) begin
        r_count <= '0;
      end
    end
  end

  assign o_trig_out    = r_trig;
  assign o_status      = r_status;
  assign o_event_count = r_count;
  assign o_armed       = (r_state == S_ARMED);

endmodule
